chebyshev_sequencer: RTL and testbench
======================================

// Module: chebyshev_sequencer
// PURPOSE
// Sequences one Chebyshev polynomial evaluation through the chebyshev_computation datapath.
// Accepts an operand x via a valid/ready handshake and holds ORDER+1 coefficients in a register file.
// Streams (x, c_k) pairs into the datapath, highest order first, one pair per cycle.
// Waits out the datapath pipeline, captures the result and pulses result_valid.
// Sits between the host/coefficient loader and the datapath, and owns the datapath's input ports.
// PARAMETERS
// WL          4  word length of x, dp_data and result (matches datapath WL)
// CL          4  word length of coefficients (matches datapath CL)
// ORDER       4  polynomial order; ORDER+1 coefficients, ORDER>=1
// DP_LATENCY  2  datapath cycles from input sample to valid dp_result, >=1
// PORTS
// clock          in   1      rising-edge clock
// resetn         in   1      asynchronous active-low reset
// in_valid       in   1      x_in valid
// in_ready       out  1      sequencer can accept x_in
// x_in           in   WL     signed evaluation point
// abort          in   1      synchronous cancel of the current evaluation
// coef_wr_en     in   1      coefficient write strobe
// coef_wr_addr   in   clog2(ORDER+1)  coefficient index k
// coef_wr_data   in   CL     signed coefficient c_k
// coef_wr_err    out  1      1-cycle pulse: write rejected
// dp_data_in     out  WL     to datapath data_in (latched x)
// dp_coeff_in    out  CL     to datapath coeff_in
// dp_valid       out  1      dp_data_in/dp_coeff_in are meaningful this cycle
// dp_first       out  1      first pair of the evaluation (datapath clears its state)
// dp_last        out  1      last pair of the evaluation
// dp_result      in   WL     from datapath data_out
// result         out  WL     captured evaluation result
// result_valid   out  1      1-cycle pulse: result updated
// busy           out  1      evaluation in progress (state != IDLE)
// BEHAVIOUR
// Reset (async, resetn=0): state=IDLE; all outputs 0 except in_ready=1; coefficient file cleared to 0; counters 0.
// All outputs are registered except in_ready, which is decoded from state (=1 iff IDLE).
// FSM IDLE -> ISSUE -> DRAIN -> IDLE.
//  IDLE: in_ready=1. At an edge with in_valid=1, latch x_in and go to ISSUE with k=ORDER.
//  ISSUE: each cycle dp_valid=1, dp_data_in=x, dp_coeff_in=c_k, and k decrements.
//    dp_first=1 when k=ORDER. dp_last=1 when k=0.
//    After k=0, go to DRAIN and load the latency counter with DP_LATENCY.
//  DRAIN: dp_valid=0 and the counter decrements. At the edge where the counter reaches 0,
//    result<=dp_result, result_valid<=1 for one cycle, and go to IDLE.
// Latency: if acceptance occurs in cycle N, dp_valid is high in cycles N+1..N+ORDER+1,
//   and result_valid is high in cycle N+ORDER+DP_LATENCY+2. Throughput: one evaluation per ORDER+DP_LATENCY+3 cycles.
// in_valid while busy: not accepted (in_ready=0). The host holds x_in/in_valid until accepted.
// Coefficient writes: accepted only in IDLE with coef_wr_addr<=ORDER.
//   Writes while busy or with an out-of-range address are discarded and pulse coef_wr_err next cycle.
//   A write and an acceptance in the same IDLE cycle: the write lands first, so the new coefficient is used.
// abort=1 while busy: next state IDLE. dp_valid/dp_first/dp_last drop the next cycle,
//   and no result_valid is produced for that evaluation. abort in IDLE is ignored.
//   abort has priority over the DRAIN capture in the same cycle.
// Reset mid-operation: immediate return to the reset state, coefficients lost, no result_valid.
// Datapath values are passed through without arithmetic here; widths match the datapath (no widening).
// TESTING
// Reset: resetn=0 mid-ISSUE -> busy=0, dp_valid=0, in_ready=1 immediately; later result_valid never fires.
// Basic eval (ORDER=2, DP_LATENCY=2): c0..c2=1,2,3, x_in=4'b01_00 accepted in cycle 0 ->
//   dp_valid in cycles 1-3, dp_coeff_in 3,2,1, dp_first cycle 1, dp_last cycle 3,
//   result_valid cycle 6 with result = dp_result sampled in cycle 5.
// Back-pressure: in_valid held high through a busy eval -> in_ready=0 for 6 cycles; second x accepted the cycle after result_valid.
// Bad writes: coef_wr_en during ISSUE, and addr=3 with ORDER=2 -> coef_wr_err pulse each time, coefficients unchanged (re-run eval matches).
// Abort: abort=1 in cycle 2 of ISSUE -> dp_valid=0 from cycle 3, in_ready=1, no result_valid; the next eval runs normally.
// Same-cycle write+accept: write c2=5 with in_valid in IDLE -> first dp_coeff_in=5.

Source files
------------

// File: rtl/chebyshev_sequencer.sv
// Sequences one Chebyshev evaluation: latches x, streams (x, c_k) pairs highest order first into
// the datapath, waits out its latency and captures the result.
module chebyshev_sequencer #(
  parameter int unsigned WL         = 4,
  parameter int unsigned CL         = 4,
  parameter int unsigned ORDER      = 4,
  parameter int unsigned DP_LATENCY = 2
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [WL-1:0]             x_in,
  input  logic                             abort,
  input  logic                             coef_wr_en,
  input  logic [$clog2(ORDER+1)-1:0]       coef_wr_addr,
  input  logic signed [CL-1:0]             coef_wr_data,
  output logic                             coef_wr_err,
  output logic signed [WL-1:0]             dp_data_in,
  output logic signed [CL-1:0]             dp_coeff_in,
  output logic                             dp_valid,
  output logic                             dp_first,
  output logic                             dp_last,
  input  logic signed [WL-1:0]             dp_result,
  output logic signed [WL-1:0]             result,
  output logic                             result_valid,
  output logic                             busy
);

  localparam int unsigned AW = $clog2(ORDER + 1);
  localparam int unsigned LW = $clog2(DP_LATENCY + 1);
  localparam logic [AW-1:0] KMax    = AW'(ORDER);
  localparam logic [LW-1:0] LatInit = LW'(DP_LATENCY);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         k_q, k_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic signed [WL-1:0]  x_q, x_d;
  logic signed [CL-1:0]  coef_q [ORDER+1];
  logic signed [CL-1:0]  coef_d [ORDER+1];
  logic signed [CL-1:0]  dp_coeff_q, dp_coeff_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_first_q, dp_first_d;
  logic                  dp_last_q, dp_last_d;
  logic signed [WL-1:0]  result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic                  coef_wr_err_q, coef_wr_err_d;
  logic                  wr_ok;

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    cnt_d          = cnt_q;
    x_d            = x_q;
    coef_d         = coef_q;
    dp_coeff_d     = dp_coeff_q;
    dp_valid_d     = dp_valid_q;
    dp_first_d     = dp_first_q;
    dp_last_d      = dp_last_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    wr_ok         = coef_wr_en && (state_q == StIdle) && (coef_wr_addr <= KMax);
    coef_wr_err_d = coef_wr_en && !wr_ok;
    if (wr_ok) begin
      coef_d[coef_wr_addr] = coef_wr_data;
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d    = StIssue;
          x_d        = x_in;
          k_d        = KMax;
          // Read through coef_d so a same-cycle write to c_ORDER is used.
          dp_coeff_d = coef_d[KMax];
          dp_valid_d = 1'b1;
          dp_first_d = 1'b1;
          dp_last_d  = 1'b0;
        end
      end
      StIssue: begin
        dp_first_d = 1'b0;
        if (k_q == '0) begin
          state_d    = StDrain;
          cnt_d      = LatInit;
          dp_valid_d = 1'b0;
          dp_last_d  = 1'b0;
        end else begin
          k_d        = k_q - AW'(1);
          dp_coeff_d = coef_q[k_d];
          dp_last_d  = (k_d == '0);
        end
      end
      StDrain: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            result_d       = dp_result;
            result_valid_d = 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d        = StIdle;
      dp_valid_d     = 1'b0;
      dp_first_d     = 1'b0;
      dp_last_d      = 1'b0;
      result_d       = result_q;
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      k_q            <= '0;
      cnt_q          <= '0;
      x_q            <= '0;
      coef_q         <= '{default: '0};
      dp_coeff_q     <= '0;
      dp_valid_q     <= 1'b0;
      dp_first_q     <= 1'b0;
      dp_last_q      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      coef_wr_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      cnt_q          <= cnt_d;
      x_q            <= x_d;
      coef_q         <= coef_d;
      dp_coeff_q     <= dp_coeff_d;
      dp_valid_q     <= dp_valid_d;
      dp_first_q     <= dp_first_d;
      dp_last_q      <= dp_last_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      coef_wr_err_q  <= coef_wr_err_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign dp_data_in   = x_q;
  assign dp_coeff_in  = dp_coeff_q;
  assign dp_valid     = dp_valid_q;
  assign dp_first     = dp_first_q;
  assign dp_last      = dp_last_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign coef_wr_err  = coef_wr_err_q;

endmodule

// File: tb/tb_chebyshev_sequencer.sv
// Bench for chebyshev_sequencer: random evaluations checked against a cycle-schedule model
// derived from the acceptance cycle, ORDER and DP_LATENCY.
module tb_chebyshev_sequencer;

  localparam int ORDER = 2;
  localparam int LAT   = 2;

  logic       clock;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x_in;
  logic       abort;
  logic       coef_wr_en;
  logic [1:0] coef_wr_addr;
  logic [3:0] coef_wr_data;
  logic       coef_wr_err;
  logic [3:0] dp_data_in;
  logic [3:0] dp_coeff_in;
  logic       dp_valid;
  logic       dp_first;
  logic       dp_last;
  logic [3:0] dp_result;
  logic [3:0] result;
  logic       result_valid;
  logic       busy;

  logic [3:0] cm [ORDER+1];
  int n_vec = 0;
  int n_err = 0;

  chebyshev_sequencer #(
    .WL(4), .CL(4), .ORDER(ORDER), .DP_LATENCY(LAT)
  ) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .abort(abort), .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data), .coef_wr_err(coef_wr_err), .dp_data_in(dp_data_in),
    .dp_coeff_in(dp_coeff_in), .dp_valid(dp_valid), .dp_first(dp_first), .dp_last(dp_last),
    .dp_result(dp_result), .result(result), .result_valid(result_valid), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr_coef(input int addr, input logic [3:0] d);
    @(posedge clock); #1;
    coef_wr_en = 1'b1; coef_wr_addr = addr[1:0]; coef_wr_data = d;
    @(posedge clock); #1;
    coef_wr_en = 1'b0;
    @(negedge clock);
    check_eq("wr_err", coef_wr_err, addr > ORDER);
    if (addr <= ORDER) cm[addr] = d;
  endtask

  // Cycle 0 is the acceptance cycle; cycles 1..ORDER+LAT+2 are checked against the schedule.
  task automatic do_eval(input logic [3:0] x, input int abort_at, input bit hold,
                         input bit bad_wr, input bit same_wr, input logic [3:0] same_data);
    logic [3:0] rexp;
    bit aborted;
    bit dv_e;
    int rv_cyc;
    rexp = '0;
    aborted = 0;
    rv_cyc = ORDER + LAT + 2;
    @(posedge clock); #1;
    in_valid = 1'b1; x_in = x; dp_result = 4'($urandom);
    if (same_wr) begin
      coef_wr_en = 1'b1; coef_wr_addr = 2'(ORDER); coef_wr_data = same_data;
      cm[ORDER] = same_data;
    end
    @(negedge clock);
    check_eq("rdy0", in_ready, 1);
    for (int c = 1; c <= rv_cyc; c++) begin
      @(posedge clock); #1;
      if (c - 1 == abort_at) aborted = 1;
      in_valid     = hold;
      coef_wr_en   = bad_wr && (c == 2);
      coef_wr_addr = 2'd0;
      coef_wr_data = 4'($urandom);
      abort        = (c == abort_at);
      dp_result    = 4'($urandom);
      if (c == rv_cyc - 1) rexp = dp_result;
      @(negedge clock);
      dv_e = !aborted && (c <= ORDER + 1);
      check_eq("dp_valid", dp_valid, dv_e);
      check_eq("dp_first", dp_first, dv_e && (c == 1));
      check_eq("dp_last", dp_last, dv_e && (c == ORDER + 1));
      if (dv_e) begin
        check_eq("dp_coeff", dp_coeff_in, cm[ORDER+1-c]);
        check_eq("dp_data", dp_data_in, x);
      end
      check_eq("res_valid", result_valid, !aborted && (c == rv_cyc));
      if (!aborted && (c == rv_cyc)) check_eq("result", result, rexp);
      check_eq("in_ready", in_ready, aborted);
      check_eq("busy", busy, !aborted);
      check_eq("wr_err", coef_wr_err, bad_wr && (c == 3));
    end
    abort = 1'b0;
    coef_wr_en = 1'b0;
  endtask

  initial begin
    logic [3:0] x;
    resetn = 1'b0; in_valid = 1'b0; x_in = '0; abort = 1'b0;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0; dp_result = '0;
    for (int i = 0; i <= ORDER; i++) cm[i] = '0;
    #12;
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_dpv", dp_valid, 0);
    check_eq("rst_rv", result_valid, 0);
    check_eq("rst_res", result, 0);
    check_eq("rst_err", coef_wr_err, 0);
    resetn = 1'b1;

    // Basic evaluation with c0..c2 = 1,2,3.
    wr_coef(0, 4'd1); wr_coef(1, 4'd2); wr_coef(2, 4'd3);
    do_eval(4'b0100, -1, 0, 0, 0, 4'd0);

    // Back-pressure: x held valid through the busy evaluation.
    do_eval(4'd6, -1, 1, 0, 0, 4'd0);
    do_eval(4'd6, -1, 0, 0, 0, 4'd0);

    // Rejected writes leave the coefficient file untouched.
    do_eval(4'd3, -1, 0, 1, 0, 4'd0);
    wr_coef(3, 4'hf);
    do_eval(4'd3, -1, 0, 0, 0, 4'd0);

    // Abort mid-issue, then a normal evaluation.
    do_eval(4'd9, 2, 0, 0, 0, 4'd0);
    do_eval(4'd9, -1, 0, 0, 0, 4'd0);

    // Write and acceptance in the same idle cycle.
    do_eval(4'd2, -1, 0, 0, 1, 4'd5);

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 1) == 1) wr_coef(int'($urandom_range(0, 3)), 4'($urandom));
      x = 4'($urandom);
      do_eval(x, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ORDER + LAT + 2)) : -1,
              0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 4'($urandom));
    end

    // Asynchronous reset in the middle of ISSUE.
    @(posedge clock); #1;
    in_valid = 1'b1; x_in = 4'd7;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_dpv", dp_valid, 0);
    check_eq("mid_rst_rdy", in_ready, 1);
    for (int i = 0; i <= ORDER; i++) cm[i] = '0;
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check_eq("mid_rst_rv", result_valid, 0);
    end
    do_eval(4'd5, -1, 0, 0, 0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
